// File: rtl/cyclotron_mem_initiator.sv
// Tagged memory initiator: issues core commands as tagged memory requests,
// tracks outstanding tags and returns responses to the core in arrival order.
// Ports:
//   clock, reset (async, active-low)
//   cmd_*  : core command in (valid/ready, store, address, data, mask, meta)
//   req_*  : memory request out (valid/ready, store, address, tag, data, mask)
//   resp_* : memory response in (valid/ready, tag, data)
//   done_* : completion out (valid/ready, store, meta, data)
//   outstanding, err_unknown_tag : busy-tag count, sticky bad-tag flag
module cyclotron_mem_initiator #(
  parameter int ARCH_LEN = 32,
  parameter int LSU_LANES = 16,
  parameter int TAG_BITS = 32,
  parameter int NUM_TAGS = 8,
  parameter int META_BITS = 16,
  localparam int DATA_WIDTH = LSU_LANES * ARCH_LEN,
  localparam int MASK_WIDTH = DATA_WIDTH / 8,
  localparam int CNT_W = $clog2(NUM_TAGS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_store,
  input  logic [ARCH_LEN-1:0]   cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [MASK_WIDTH-1:0] cmd_mask,
  input  logic [META_BITS-1:0]  cmd_meta,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_store,
  output logic [ARCH_LEN-1:0]   req_address,
  output logic [TAG_BITS-1:0]   req_tag,
  output logic [DATA_WIDTH-1:0] req_data,
  output logic [MASK_WIDTH-1:0] req_mask,
  input  logic                  resp_valid,
  output logic                  resp_ready,
  input  logic [TAG_BITS-1:0]   resp_tag,
  input  logic [DATA_WIDTH-1:0] resp_data,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  done_store,
  output logic [META_BITS-1:0]  done_meta,
  output logic [DATA_WIDTH-1:0] done_data,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  err_unknown_tag
);

  localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

  logic [NUM_TAGS-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tab_store_q [NUM_TAGS];
  logic [META_BITS-1:0]  tab_meta_q [NUM_TAGS];

  logic                  req_valid_q;
  logic                  req_store_q;
  logic [ARCH_LEN-1:0]   req_addr_q;
  logic [TAG_BITS-1:0]   req_tag_q;
  logic [DATA_WIDTH-1:0] req_data_q;
  logic [MASK_WIDTH-1:0] req_mask_q;

  logic                  done_valid_q;
  logic                  done_store_q;
  logic [META_BITS-1:0]  done_meta_q;
  logic [DATA_WIDTH-1:0] done_data_q;
  logic                  err_q;

  logic [IDX_W-1:0]      alloc_idx;
  logic [IDX_W-1:0]      resp_idx;
  logic [TAG_BITS-1:0]   alloc_tag;
  logic                  any_free;
  logic                  cmd_fire, req_fire, done_fire;
  logic                  resp_fire, resp_in_range, resp_hit;

  // Lowest-index free tag, taken from the pre-edge bitmap.
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    alloc_tag = '0;
    alloc_tag[IDX_W-1:0] = alloc_idx;
  end

  assign any_free   = ~&busy_q;
  assign cmd_ready  = any_free && (!req_valid_q || req_ready);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign req_fire   = req_valid_q && req_ready;
  assign resp_ready = !done_valid_q || done_ready;
  assign resp_fire  = resp_valid && resp_ready;
  assign done_fire  = done_valid_q && done_ready;

  // Extra top bit keeps the range check exact even at NUM_TAGS == 2^TAG_BITS.
  assign resp_in_range = {1'b0, resp_tag} < (TAG_BITS + 1)'(NUM_TAGS);
  assign resp_idx      = resp_tag[IDX_W-1:0];
  assign resp_hit      = resp_fire && resp_in_range && busy_q[resp_idx];

  always_comb begin
    busy_d = busy_q;
    if (resp_hit) busy_d[resp_idx] = 1'b0;
    if (cmd_fire) busy_d[alloc_idx] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      cmd_fire && !resp_hit: cnt_d = cnt_q + CNT_W'(1);
      resp_hit && !cmd_fire: cnt_d = cnt_q - CNT_W'(1);
      default:               cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      req_valid_q  <= 1'b0;
      req_store_q  <= 1'b0;
      req_addr_q   <= '0;
      req_tag_q    <= '0;
      req_data_q   <= '0;
      req_mask_q   <= '0;
      done_valid_q <= 1'b0;
      done_store_q <= 1'b0;
      done_meta_q  <= '0;
      done_data_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (resp_fire && !resp_hit) err_q <= 1'b1;

      if (cmd_fire) begin
        req_valid_q <= 1'b1;
        req_store_q <= cmd_store;
        req_addr_q  <= cmd_address;
        req_tag_q   <= alloc_tag;
        req_data_q  <= cmd_data;
        req_mask_q  <= cmd_mask;
      end else if (req_fire) begin
        req_valid_q <= 1'b0;
      end

      if (resp_hit) begin
        done_valid_q <= 1'b1;
        done_store_q <= tab_store_q[resp_idx];
        done_meta_q  <= tab_meta_q[resp_idx];
        done_data_q  <= resp_data;
      end else if (done_fire) begin
        done_valid_q <= 1'b0;
      end
    end
  end

  // Per-tag table is only meaningful while its busy bit is set.
  always_ff @(posedge clock) begin
    if (cmd_fire) begin
      tab_store_q[alloc_idx] <= cmd_store;
      tab_meta_q[alloc_idx]  <= cmd_meta;
    end
  end

  assign req_valid       = req_valid_q;
  assign req_store       = req_store_q;
  assign req_address     = req_addr_q;
  assign req_tag         = req_tag_q;
  assign req_data        = req_data_q;
  assign req_mask        = req_mask_q;
  assign done_valid      = done_valid_q;
  assign done_store      = done_store_q;
  assign done_meta       = done_meta_q;
  assign done_data       = done_data_q;
  assign outstanding     = cnt_q;
  assign err_unknown_tag = err_q;

endmodule

// File: tb/tb_cyclotron_mem_initiator.sv
// Directed bench for cyclotron_mem_initiator with a request/completion
// scoreboard driven by a small reference model of the tag bitmap.
module tb_cyclotron_mem_initiator;

  localparam int DW = 512;
  localparam int MW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_store;
  logic [31:0]   cmd_address;
  logic [DW-1:0] cmd_data;
  logic [MW-1:0] cmd_mask;
  logic [15:0]   cmd_meta;
  logic          req_valid, req_ready, req_store;
  logic [31:0]   req_address, req_tag;
  logic [DW-1:0] req_data;
  logic [MW-1:0] req_mask;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_tag;
  logic [DW-1:0] resp_data;
  logic          done_valid, done_ready, done_store;
  logic [15:0]   done_meta;
  logic [DW-1:0] done_data;
  logic [3:0]    outstanding;
  logic          err_unknown_tag;

  cyclotron_mem_initiator dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_store(cmd_store), .cmd_address(cmd_address),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_meta(cmd_meta),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_address(req_address),
    .req_tag(req_tag), .req_data(req_data), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_tag(resp_tag), .resp_data(resp_data),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_store(done_store), .done_meta(done_meta),
    .done_data(done_data), .outstanding(outstanding),
    .err_unknown_tag(err_unknown_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          st;
    logic [31:0]   addr;
    logic [31:0]   tag;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } req_t;

  typedef struct {
    logic          st;
    logic [15:0]   meta;
    logic [DW-1:0] data;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];
  done_t last_done;
  req_t  last_req;

  logic        mb[8];
  logic        mst[8];
  logic [15:0] mmeta[8];
  int          mout;
  logic        merr;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 8; i++) if (!mb[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mb[i] = 1'b0;
    mout = 0;
    merr = 1'b0;
    req_q.delete();
    done_q.delete();
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Model side of a command fire: allocate from the pre-edge bitmap.
  task automatic model_cmd();
    req_t r;
    int t;
    t = lowest_free();
    r.st = cmd_store; r.addr = cmd_address; r.tag = t;
    r.data = cmd_data; r.mask = cmd_mask;
    req_q.push_back(r);
    mst[t] = cmd_store;
    mmeta[t] = cmd_meta;
    mb[t] = 1'b1;
    mout++;
  endtask

  // Model side of a response fire; returns 1 when it should complete.
  function automatic logic model_resp(input logic [31:0] tag,
                                      input logic [DW-1:0] d);
    done_t e;
    if (tag < 8 && mb[tag[2:0]]) begin
      e.st = mst[tag[2:0]]; e.meta = mmeta[tag[2:0]]; e.data = d;
      done_q.push_back(e);
      mb[tag[2:0]] = 1'b0;
      mout--;
      return 1'b1;
    end
    merr = 1'b1;
    return 1'b0;
  endfunction

  task automatic check_req();
    chk("req_valid", req_valid, 1);
    if (req_q.size() == 0) begin
      chk("req_queue_empty", 1, 0);
    end else begin
      last_req = req_q.pop_front();
      chk("req_tag", req_tag, last_req.tag);
      chk("req_address", req_address, last_req.addr);
      chk("req_store", req_store, last_req.st);
      chk("req_data", req_data, last_req.data);
      chk("req_mask", req_mask, last_req.mask);
    end
  endtask

  task automatic check_done();
    chk("done_valid", done_valid, 1);
    if (done_q.size() == 0) begin
      chk("done_queue_empty", 1, 0);
    end else begin
      last_done = done_q.pop_front();
      chk("done_store", done_store, last_done.st);
      chk("done_meta", done_meta, last_done.meta);
      chk("done_data", done_data, last_done.data);
    end
  endtask

  task automatic issue(input logic st, input logic [31:0] addr,
                       input logic [15:0] meta);
    cmd_valid = 1'b1; cmd_store = st; cmd_address = addr;
    cmd_meta = meta; cmd_data = rnd_data(); cmd_mask = {$urandom, $urandom};
    #1;
    chk("cmd_ready_issue", cmd_ready, 1);
    model_cmd();
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    check_req();
  endtask

  task automatic respond(input logic [31:0] tag);
    logic ok;
    resp_valid = 1'b1; resp_tag = tag; resp_data = rnd_data();
    #1;
    chk("resp_ready", resp_ready, 1);
    ok = model_resp(tag, resp_data);
    @(posedge clock);
    #1;
    resp_valid = 1'b0;
    if (ok) begin
      check_done();
    end else begin
      chk("done_valid_drop", done_valid, 0);
    end
    chk("err_unknown_tag", err_unknown_tag, merr);
    chk("outstanding", outstanding, mout);
  endtask

  initial begin
    int held_tag;
    logic [31:0] held_addr;
    logic ok;
    reset = 1'b0;
    cmd_valid = 0; cmd_store = 0; cmd_address = 0; cmd_data = '0;
    cmd_mask = '0; cmd_meta = 0; req_ready = 1; resp_valid = 0;
    resp_tag = 0; resp_data = '0; done_ready = 1;
    model_reset();
    step(); step();
    chk("rst_req_valid", req_valid, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_err", err_unknown_tag, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_req_tag", req_tag, 0);
    chk("rst_req_address", req_address, 0);
    chk("rst_done_data", done_data, 0);
    chk("rst_done_meta", done_meta, 0);
    reset = 1'b1;
    step();

    // single load
    issue(1'b0, 32'h100, 16'h5);
    chk("single_tag0", last_req.tag, 0);
    step();
    chk("req_valid_clear", req_valid, 0);
    chk("outstanding_1", outstanding, 1);
    respond(0);
    step();
    chk("done_valid_clear", done_valid, 0);
    chk("outstanding_0", outstanding, 0);

    // fill all tags back to back
    for (int i = 0; i < 8; i++) issue(i[0], 32'h200 + i, 16'(i + 10));
    chk("fill_outstanding", outstanding, 8);
    chk("fill_cmd_ready", cmd_ready, 0);
    step();
    chk("fill_drained", req_valid, 0);
    chk("full_cmd_ready", cmd_ready, 0);
    respond(3);
    chk("freed_cmd_ready", cmd_ready, 1);
    issue(1'b1, 32'h300, 16'h33);
    chk("reuse_tag3", last_req.tag, 3);
    step();

    // request backpressure
    respond(0);
    respond(1);
    req_ready = 1'b0;
    issue(1'b0, 32'h400, 16'h44);
    held_tag = last_req.tag;
    held_addr = last_req.addr;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_req_valid", req_valid, 1);
      chk("bp_req_tag", req_tag, held_tag);
      chk("bp_req_addr", req_address, held_addr);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    req_ready = 1'b1;
    step();
    chk("bp_release", req_valid, 0);

    // completion backpressure
    done_ready = 1'b0;
    respond(5);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("dbp_resp_ready", resp_ready, 0);
      chk("dbp_done_valid", done_valid, 1);
      chk("dbp_done_meta", done_meta, last_done.meta);
      chk("dbp_done_data", done_data, last_done.data);
    end
    done_ready = 1'b1;
    step();
    chk("dbp_release", done_valid, 0);

    // simultaneous cmd fire and free: tag 0 freed, tag 1 must be taken
    cmd_valid = 1; cmd_store = 0; cmd_address = 32'h500;
    cmd_meta = 16'h55; cmd_data = rnd_data(); cmd_mask = '1;
    resp_valid = 1; resp_tag = 0; resp_data = rnd_data();
    #1;
    chk("sim_cmd_ready", cmd_ready, 1);
    chk("sim_resp_ready", resp_ready, 1);
    model_cmd();
    ok = model_resp(0, resp_data);
    step();
    cmd_valid = 0; resp_valid = 0;
    check_req();
    chk("sim_tag1", last_req.tag, 1);
    check_done();
    chk("sim_outstanding", outstanding, mout);
    issue(1'b1, 32'h600, 16'h66);
    chk("sim_reuse_tag0", last_req.tag, 0);
    step();

    // unknown tags
    respond(9);
    step();
    respond(5);
    step();
    respond(2);
    chk("err_sticky", err_unknown_tag, 1);
    step();

    // reset in flight
    done_ready = 1'b0;
    respond(4);
    issue(1'b0, 32'h700, 16'h77);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_outstanding", outstanding, 0);
    chk("arst_req_valid", req_valid, 0);
    chk("arst_done_valid", done_valid, 0);
    chk("arst_err", err_unknown_tag, 0);
    model_reset();
    done_ready = 1'b1;
    step();
    reset = 1'b1;
    step();
    respond(1);
    issue(1'b0, 32'h800, 16'h88);
    chk("post_reset_tag0", last_req.tag, 0);
    step();
    chk("final_outstanding", outstanding, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cyclotron_mem_initiator.md
CYCLOTRON_MEM_INITIATOR -- requirements
Module: cyclotron_mem_initiator

Interface
REQ-001 SHALL have parameters, one per line:
- ARCH_LEN, 32, address and lane width.
- LSU_LANES, 16, lanes per request.
- TAG_BITS, 32, width of the memory-side tag.
- NUM_TAGS, 8, maximum outstanding requests, power of two, at most 2^TAG_BITS.
- META_BITS, 16, opaque core-side metadata carried per request.
REQ-002 SHALL derive DATA_WIDTH = LSU_LANES*ARCH_LEN and MASK_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have these ports, one per line (name, direction, width, meaning):
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid/cmd_ready  in/out  1/1  core command handshake.
- cmd_store  in  1  1 = store, 0 = load.
- cmd_address  in  ARCH_LEN  request address.
- cmd_data  in  DATA_WIDTH  store data.
- cmd_mask  in  MASK_WIDTH  byte enables.
- cmd_meta  in  META_BITS  core metadata.
- req_valid/req_ready  out/in  1/1  memory request handshake.
- req_store, req_address, req_tag, req_data, req_mask  out  1/ARCH_LEN/TAG_BITS/DATA_WIDTH/MASK_WIDTH  memory request fields.
- resp_valid/resp_ready  in/out  1/1  memory response handshake.
- resp_tag  in  TAG_BITS  response tag.
- resp_data  in  DATA_WIDTH  response data.
- done_valid/done_ready  out/in  1/1  completion handshake to the core.
- done_store  out  1  completed operation type.
- done_meta  out  META_BITS  metadata of the completed command.
- done_data  out  DATA_WIDTH  response data.
- outstanding  out  clog2(NUM_TAGS+1)  count of busy tags.
- err_unknown_tag  out  1  sticky error flag.

Function
REQ-004 SHALL keep a busy bitmap of NUM_TAGS entries plus a per-tag table holding {store, meta}.
REQ-005 SHALL drive cmd_ready = (any tag free) && (!req_valid || req_ready), combinationally.
REQ-006 SHALL, on a cmd fire, allocate the lowest-index free tag, set its busy bit, and write {cmd_store, cmd_meta} to the table.
REQ-007 SHALL, on the same cmd fire, load the request register so that req_valid=1 on the next cycle, with req_tag holding the allocated index zero-extended; command-to-request latency is 1 cycle.
REQ-008 SHALL hold all req_* fields stable while req_valid && !req_ready.
REQ-009 SHALL clear req_valid after a req fire unless a new cmd fires in the same cycle; back-to-back issue at 1 request per cycle SHALL be supported.
REQ-010 SHALL drive resp_ready = !done_valid || done_ready, combinationally.
REQ-011 SHALL, on a resp fire with resp_tag < NUM_TAGS and that tag busy:
- load done_store and done_meta from the table and done_data from resp_data, with done_valid=1 on the next cycle;
- clear the tag's busy bit.
REQ-012 SHALL, on a resp fire with resp_tag out of range or not busy, consume and drop the response, set err_unknown_tag, and leave done_* and the bitmap unchanged.
REQ-013 SHALL hold done_* stable while done_valid && !done_ready, and SHALL clear done_valid after a done fire unless a new valid response fires in the same cycle.
REQ-014 SHALL complete responses in arrival order; out-of-order responses relative to issue order are legal.
REQ-015 SHALL, when a tag is freed and a cmd fires in the same cycle, allocate from the pre-edge bitmap; the freed tag is reusable from the next cycle.
REQ-016 SHALL update outstanding by +1 on a cmd fire, -1 on a valid resp fire, and leave it unchanged when both occur; it SHALL never wrap.
REQ-017 SHALL keep cmd_ready=0 when all NUM_TAGS tags are busy (full), regardless of req_ready.

Reset
REQ-018 SHALL, while reset=0, asynchronously force:
- req_valid=0, done_valid=0, err_unknown_tag=0, outstanding=0;
- all busy bits=0;
- all req_* and done_* data fields=0.
REQ-019 SHALL, on reset mid-operation, discard all in-flight tags; responses arriving after reset deassertion SHALL be treated per REQ-012.
REQ-020 SHALL leave the table contents unreset.

Verification
REQ-021 Single load: cmd fire at address 0x100 with meta 0x5 -> next cycle req_valid=1, req_tag=0, req_address=0x100; resp_tag=0, resp_data=D -> next cycle done_valid=1, done_meta=0x5, done_data=D, outstanding returns to 0.
REQ-022 Fill: 8 cmds with req_ready=1 and no responses -> req_tag sequence 0..7, outstanding=8, cmd_ready=0; one resp with tag 3 -> cmd_ready=1 the cycle after the free, and the next cmd receives tag 3.
REQ-023 Backpressure: req_ready=0 for 5 cycles -> req_* stable, cmd_ready=0; done_ready=0 -> resp_ready=0 and done_* stable.
REQ-024 Simultaneous: cmd fire and valid resp fire in the same cycle -> outstanding unchanged, and the freed tag is not allocated that cycle.
REQ-025 Bad tag: resp_tag=9, or resp_tag=2 while tag 2 is free -> response consumed, err_unknown_tag=1 and sticky, done_valid stays 0.
REQ-026 Reset mid-flight: 3 tags busy, then reset pulse -> outstanding=0, req_valid=0, done_valid=0 immediately (asynchronous); first cmd after reset receives tag 0.
